// File: rtl/miner_pkg.sv
// Shared widths, checker FSM encoding and the digest byte-order helper
// used by the mining datapath.
package miner_pkg;

  localparam int HASH_W  = 256;
  localparam int NONCE_W = 32;
  localparam int NBITS_W = 32;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_EXPAND  = 2'd1;
  localparam logic [1:0] ST_COMPARE = 2'd2;
  localparam logic [1:0] ST_RESULT  = 2'd3;

  localparam logic [7:0] NBITS_EXP_MAX = 8'h20;

  // The hash core emits the digest in raw byte order; the target compare
  // needs it as a big-endian number, so byte i takes byte 31-i.
  function automatic logic [HASH_W-1:0] byte_swap(input logic [HASH_W-1:0] d);
    logic [HASH_W-1:0] r;
    r = {HASH_W{1'b0}};
    for (int i = 0; i < HASH_W/8; i++) begin
      r[8*i +: 8] = d[HASH_W-8-8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/nbits_expand.sv
// Expands a compact nbits target into the full 256-bit threshold and flags
// encodings that a valid header can never carry.
module nbits_expand
  import miner_pkg::*;
(
  input  logic [NBITS_W-1:0] nbits,
  output logic [HASH_W-1:0]  target,
  output logic               bad_nbits
);

  logic [7:0]        exp_s;
  logic [23:0]       mant_s;
  logic [HASH_W-1:0] mant_wide_s;

  assign exp_s       = nbits[31:24];
  assign mant_s      = nbits[23:0];
  assign mant_wide_s = {{(HASH_W-24){1'b0}}, mant_s};

  // A set sign bit or an exponent past 32 bytes cannot describe a target.
  assign bad_nbits = mant_s[23] | (exp_s > NBITS_EXP_MAX);

  // Byte-granular shift of the mantissa by the exponent distance from 3.
  always_comb begin
    target = {HASH_W{1'b0}};
    if (exp_s >= 8'd3) begin
      target = mant_wide_s << {exp_s - 8'd3, 3'b000};
    end else begin
      target = mant_wide_s >> {8'd3 - exp_s, 3'b000};
    end
  end

endmodule

// File: rtl/target_checker.sv
// Checks a SHA-256d digest against the header target one 32-bit word per
// cycle (most significant first) and reports hit/miss with its nonce.
module target_checker
  import miner_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               hash_valid,
  output logic               hash_ready,
  input  logic [HASH_W-1:0]  hash_in,
  input  logic [NONCE_W-1:0] nonce_in,
  input  logic [NBITS_W-1:0] nbits,
  output logic               res_valid,
  input  logic               res_ready,
  output logic               res_found,
  output logic [NONCE_W-1:0] res_nonce,
  output logic               res_bad_nbits,
  output logic [CNT_W-1:0]   found_cnt
);

  logic [1:0]         state_r;
  logic [HASH_W-1:0]  v_r;
  logic [HASH_W-1:0]  t_r;
  logic [NBITS_W-1:0] nbits_r;
  logic [2:0]         word_r;
  logic               hash_ready_r;
  logic               res_valid_r;
  logic               res_found_r;
  logic               res_bad_r;
  logic [NONCE_W-1:0] res_nonce_r;
  logic [CNT_W-1:0]   cnt_r;

  logic [HASH_W-1:0]  t_s;
  logic               bad_s;
  logic [7:0]         word_lsb_s;
  logic [31:0]        v_word_s;
  logic [31:0]        t_word_s;

  nbits_expand u_expand (
    .nbits     (nbits_r),
    .target    (t_s),
    .bad_nbits (bad_s)
  );

  assign word_lsb_s = {word_r, 5'b00000};
  assign v_word_s   = v_r[word_lsb_s +: 32];
  assign t_word_s   = t_r[word_lsb_s +: 32];

  // Job FSM: capture, expand target, word-serial compare, hold result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      v_r          <= {HASH_W{1'b0}};
      t_r          <= {HASH_W{1'b0}};
      nbits_r      <= {NBITS_W{1'b0}};
      word_r       <= 3'd0;
      hash_ready_r <= 1'b0;
      res_valid_r  <= 1'b0;
      res_found_r  <= 1'b0;
      res_bad_r    <= 1'b0;
      res_nonce_r  <= {NONCE_W{1'b0}};
      cnt_r        <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (hash_valid && hash_ready_r) begin
            v_r          <= byte_swap(hash_in);
            nbits_r      <= nbits;
            res_nonce_r  <= nonce_in;
            hash_ready_r <= 1'b0;
            state_r      <= ST_EXPAND;
          end else begin
            hash_ready_r <= 1'b1;
          end
        end
        ST_EXPAND: begin
          t_r    <= t_s;
          word_r <= 3'd7;
          if (bad_s) begin
            res_bad_r   <= 1'b1;
            res_found_r <= 1'b0;
            res_valid_r <= 1'b1;
            state_r     <= ST_RESULT;
          end else begin
            res_bad_r <= 1'b0;
            state_r   <= ST_COMPARE;
          end
        end
        ST_COMPARE: begin
          if (v_word_s != t_word_s) begin
            res_found_r <= (v_word_s < t_word_s);
            res_valid_r <= 1'b1;
            state_r     <= ST_RESULT;
          end else if (word_r == 3'd0) begin
            // Every word matched: V == T still meets the target.
            res_found_r <= 1'b1;
            res_valid_r <= 1'b1;
            state_r     <= ST_RESULT;
          end else begin
            word_r <= word_r - 3'd1;
          end
        end
        ST_RESULT: begin
          if (res_ready) begin
            res_valid_r  <= 1'b0;
            res_found_r  <= 1'b0;
            res_bad_r    <= 1'b0;
            hash_ready_r <= 1'b1;
            state_r      <= ST_IDLE;
            if (res_found_r && (cnt_r != {CNT_W{1'b1}})) begin
              cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
              cnt_r <= cnt_r;
            end
          end else begin
            state_r <= ST_RESULT;
          end
        end
        default: begin
          hash_ready_r <= 1'b0;
          res_valid_r  <= 1'b0;
          state_r      <= ST_IDLE;
        end
      endcase
    end
  end

  assign hash_ready    = hash_ready_r;
  assign res_valid     = res_valid_r;
  assign res_found     = res_found_r;
  assign res_nonce     = res_nonce_r;
  assign res_bad_nbits = res_bad_r;
  assign found_cnt     = cnt_r;

endmodule
